reorder_buffer: RTL and testbench

- Circular in-order reorder buffer (ROB) sitting between decode/issue, the execution units' common data bus (CDB), and the rename register file.
- Allocates one entry per issued instruction and publishes the destination rename tag to the register file.
- Answers operand-tag lookups from the register file and commits completed entries in order to the register file, or as store releases.
- Raises a one-cycle flush on a branch mispredict at commit.

---
 rtl/reorder_buffer.sv | 183 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates entries at issue, captures CDB
// results, answers operand tag queries and retires entries in program order.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_pred_jump,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_val,
    output logic                     full,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    output logic [4:0]               set_dep_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
    input  logic                     cdb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
    input  logic [31:0]              cdb_val,
    input  logic                     cdb_jump,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
    output logic                     rob_value1_ready,
    output logic                     rob_value2_ready,
    output logic [31:0]              rob_value1,
    output logic [31:0]              rob_value2,
    output logic [4:0]               set_reg_id,
    output logic [31:0]              set_val,
    output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
    output logic                     store_commit,
    output logic                     exit_commit,
    output logic                     rob_clear,
    output logic [31:0]              clear_pc
);

    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] DEPTH_CNT = (ROB_WIDTH_BIT + 1)'(DEPTH);
    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_BRANCH = 2'd1;
    localparam logic [1:0] T_STORE  = 2'd2;
    localparam logic [1:0] T_EXIT   = 2'd3;

    logic                     busy_r  [DEPTH];
    logic                     ready_r [DEPTH];
    logic [1:0]               type_r  [DEPTH];
    logic [4:0]               rd_r    [DEPTH];
    logic                     pred_r  [DEPTH];
    logic                     jump_r  [DEPTH];
    logic [31:0]              val_r   [DEPTH];
    logic [ROB_WIDTH_BIT-1:0] head_r;
    logic [ROB_WIDTH_BIT-1:0] tail_r;
    logic [ROB_WIDTH_BIT:0]   count_r;
    logic                     rob_clear_r;
    logic [31:0]              clear_pc_r;
    logic                     exit_r;

    logic issue_acc_s;
    logic commit_s;
    logic mispredict_s;

    // Accept/commit decisions and all combinational outputs
    always_comb begin
        full              = (count_r == DEPTH_CNT);
        issue_acc_s       = issue_valid && !full && !rob_clear_r && rdy_in;
        commit_s          = busy_r[head_r] && ready_r[head_r] && rdy_in && !rob_clear_r;
        mispredict_s      = 1'b0;
        issue_rob_id      = tail_r;
        set_dep_rob_id    = tail_r;
        set_dep_reg_id    = 5'd0;
        set_reg_id        = 5'd0;
        set_val           = 32'd0;
        set_reg_on_rob_id = head_r;
        store_commit      = 1'b0;
        rob_clear         = rob_clear_r;
        clear_pc          = clear_pc_r;
        exit_commit       = exit_r;

        if (issue_acc_s && issue_type == T_REG) begin
            set_dep_reg_id = issue_rd;
        end else begin
            set_dep_reg_id = 5'd0;
        end

        if (commit_s) begin
            case (type_r[head_r])
                T_REG: begin
                    set_reg_id = rd_r[head_r];
                    set_val    = val_r[head_r];
                end
                T_STORE:  store_commit = 1'b1;
                T_BRANCH: mispredict_s = (jump_r[head_r] != pred_r[head_r]);
                default:  store_commit = 1'b0;
            endcase
        end else begin
            set_reg_id = 5'd0;
        end

        // Same-cycle CDB result is forwarded ahead of the stored value
        if (cdb_valid && cdb_rob_id == get_rob_id1) begin
            rob_value1_ready = 1'b1;
            rob_value1       = cdb_val;
        end else begin
            rob_value1_ready = ready_r[get_rob_id1];
            rob_value1       = val_r[get_rob_id1];
        end
        if (cdb_valid && cdb_rob_id == get_rob_id2) begin
            rob_value2_ready = 1'b1;
            rob_value2       = cdb_val;
        end else begin
            rob_value2_ready = ready_r[get_rob_id2];
            rob_value2       = val_r[get_rob_id2];
        end
    end

    // Entry array, pointers, occupancy and registered flush/exit state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_r[i]  <= 1'b0;
                ready_r[i] <= 1'b0;
                type_r[i]  <= 2'd0;
                rd_r[i]    <= 5'd0;
                pred_r[i]  <= 1'b0;
                jump_r[i]  <= 1'b0;
                val_r[i]   <= 32'd0;
            end
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            rob_clear_r <= 1'b0;
            clear_pc_r  <= 32'd0;
            exit_r      <= 1'b0;
        end else if (rdy_in) begin
            if (rob_clear_r) begin
                for (int i = 0; i < DEPTH; i++) begin
                    busy_r[i]  <= 1'b0;
                    ready_r[i] <= 1'b0;
                end
                head_r      <= '0;
                tail_r      <= '0;
                count_r     <= '0;
                rob_clear_r <= 1'b0;
            end else begin
                if (cdb_valid && busy_r[cdb_rob_id]) begin
                    ready_r[cdb_rob_id] <= 1'b1;
                    val_r[cdb_rob_id]   <= cdb_val;
                    jump_r[cdb_rob_id]  <= cdb_jump;
                end
                if (issue_acc_s) begin
                    busy_r[tail_r]  <= 1'b1;
                    ready_r[tail_r] <= issue_ready;
                    type_r[tail_r]  <= issue_type;
                    rd_r[tail_r]    <= issue_rd;
                    pred_r[tail_r]  <= issue_pred_jump;
                    jump_r[tail_r]  <= issue_pred_jump;
                    val_r[tail_r]   <= issue_val;
                    tail_r          <= tail_r + ROB_WIDTH_BIT'(1);
                end
                // Freeing the head never collides with the issue slot: head==tail only when empty or full
                if (commit_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= head_r + ROB_WIDTH_BIT'(1);
                    if (type_r[head_r] == T_EXIT) begin
                        exit_r <= 1'b1;
                    end
                    if (mispredict_s) begin
                        rob_clear_r <= 1'b1;
                        clear_pc_r  <= val_r[head_r];
                    end
                end
                case ({issue_acc_s, commit_s})
                    2'b10:   count_r <= count_r + (ROB_WIDTH_BIT + 1)'(1);
                    2'b01:   count_r <= count_r - (ROB_WIDTH_BIT + 1)'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario-driven bench for reorder_buffer with a commit-order scoreboard.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic        issue_pred_jump;
    logic        issue_ready;
    logic [31:0] issue_val;
    logic        full;
    logic [2:0]  issue_rob_id;
    logic [4:0]  set_dep_reg_id;
    logic [2:0]  set_dep_rob_id;
    logic        cdb_valid;
    logic [2:0]  cdb_rob_id;
    logic [31:0] cdb_val;
    logic        cdb_jump;
    logic [2:0]  get_rob_id1, get_rob_id2;
    logic        rob_value1_ready, rob_value2_ready;
    logic [31:0] rob_value1, rob_value2;
    logic [4:0]  set_reg_id;
    logic [31:0] set_val;
    logic [2:0]  set_reg_on_rob_id;
    logic        store_commit;
    logic        exit_commit;
    logic        rob_clear;
    logic [31:0] clear_pc;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [2:0]  id;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int tests = 0;
    int fails = 0;

    reorder_buffer #(.ROB_WIDTH_BIT(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_jump(issue_pred_jump), .issue_ready(issue_ready), .issue_val(issue_val),
        .full(full), .issue_rob_id(issue_rob_id),
        .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .cdb_jump(cdb_jump),
        .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
        .store_commit(store_commit), .exit_commit(exit_commit),
        .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic drive_idle();
        issue_valid     = 1'b0;
        issue_type      = 2'd0;
        issue_rd        = 5'd0;
        issue_pred_jump = 1'b0;
        issue_ready     = 1'b0;
        issue_val       = 32'd0;
        cdb_valid       = 1'b0;
        cdb_rob_id      = 3'd0;
        cdb_val         = 32'd0;
        cdb_jump        = 1'b0;
        get_rob_id1     = 3'd0;
        get_rob_id2     = 3'd0;
    endtask

    task automatic drive_issue(input logic [1:0] t, input logic [4:0] rd, input logic pj,
                               input logic rdy, input logic [31:0] v);
        issue_valid     = 1'b1;
        issue_type      = t;
        issue_rd        = rd;
        issue_pred_jump = pj;
        issue_ready     = rdy;
        issue_val       = v;
    endtask

    task automatic drive_cdb(input logic [2:0] id, input logic [31:0] v, input logic j);
        cdb_valid  = 1'b1;
        cdb_rob_id = id;
        cdb_val    = v;
        cdb_jump   = j;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        drive_idle();
        rdy_in = 1'b1;
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            drive_idle();
            drive_issue(2'd0, 5'(i + 1), 1'b0, 1'b0, 32'd0);
        end
        @(negedge clk_in);
        drive_idle();
        #1;
        tests++;
        if (issue_rob_id !== 3'd3) begin
            fails++; $display("FAIL pre_reset_tail got=%0d want=3", issue_rob_id);
        end
        rst_in = 1'b0;
        #1;
        tests++;
        if (full !== 1'b0 || set_reg_id !== 5'd0 || rob_clear !== 1'b0 || issue_rob_id !== 3'd0
            || exit_commit !== 1'b0 || store_commit !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got full=%b reg=%0d clr=%b tail=%0d exit=%b st=%b want all 0",
                     full, set_reg_id, rob_clear, issue_rob_id, exit_commit, store_commit);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        drive_issue(2'd0, 5'd4, 1'b0, 1'b0, 32'd0);
        #1;
        tests++;
        if (issue_rob_id !== 3'd0 || set_dep_reg_id !== 5'd4) begin
            fails++; $display("FAIL first_issue_after_reset got id=%0d dep=%0d want 0/4",
                              issue_rob_id, set_dep_reg_id);
        end
        @(negedge clk_in);
        drive_idle();
    endtask

    task automatic test_basic();
        do_reset();
        @(negedge clk_in);
        drive_issue(2'd0, 5'd5, 1'b0, 1'b0, 32'd0);
        exp_q.push_back('{rd: 5'd5, val: 32'h1234, id: 3'd0});
        #1;
        tests++;
        if (set_dep_reg_id !== 5'd5 || set_dep_rob_id !== 3'd0) begin
            fails++; $display("FAIL basic_set_dep got reg=%0d rob=%0d want 5/0", set_dep_reg_id, set_dep_rob_id);
        end
        @(negedge clk_in);
        drive_idle();
        get_rob_id1 = 3'd0;
        #1;
        tests++;
        if (rob_value1_ready !== 1'b0) begin
            fails++; $display("FAIL basic_query_not_ready got=%b want=0", rob_value1_ready);
        end
        drive_cdb(3'd0, 32'h1234, 1'b0);
        #1;
        tests++;
        if (rob_value1_ready !== 1'b1 || rob_value1 !== 32'h1234 || set_reg_id !== 5'd0) begin
            fails++; $display("FAIL basic_cdb_forward got rdy=%b val=%h reg=%0d want 1/1234/0",
                              rob_value1_ready, rob_value1, set_reg_id);
        end
        @(negedge clk_in);
        drive_idle();
        #1;
        tests++;
        if (set_reg_id === 5'd0 || exp_q.size() == 0) begin
            fails++; $display("FAIL basic_commit got reg=%0d want 5", set_reg_id);
        end else begin
            e = exp_q.pop_front();
            if (set_reg_id !== e.rd || set_val !== e.val || set_reg_on_rob_id !== e.id) begin
                fails++; $display("FAIL basic_commit got %0d/%h/%0d want %0d/%h/%0d",
                                  set_reg_id, set_val, set_reg_on_rob_id, e.rd, e.val, e.id);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            drive_issue(2'd0, 5'(i + 1), 1'b0, 1'b0, 32'd0);
            #1;
            tests++;
            if (issue_rob_id !== 3'(i) || full !== 1'b0) begin
                fails++; $display("FAIL full_fill_%0d got id=%0d full=%b want %0d/0", i, issue_rob_id, full, i);
            end
        end
        @(negedge clk_in);
        drive_issue(2'd0, 5'd20, 1'b0, 1'b0, 32'd0);
        #1;
        tests++;
        if (full !== 1'b1 || set_dep_reg_id !== 5'd0) begin
            fails++; $display("FAIL full_ninth_refused got full=%b dep=%0d want 1/0", full, set_dep_reg_id);
        end
        drive_idle();
        drive_cdb(3'd0, 32'hA0, 1'b0);
        exp_q.push_back('{rd: 5'd1, val: 32'hA0, id: 3'd0});
        @(negedge clk_in);
        drive_idle();
        drive_issue(2'd0, 5'd9, 1'b0, 1'b0, 32'd0);
        #1;
        tests++;
        if (full !== 1'b1 || set_dep_reg_id !== 5'd0) begin
            fails++; $display("FAIL full_in_commit_cycle got full=%b dep=%0d want 1/0", full, set_dep_reg_id);
        end
        tests++;
        if (set_reg_id === 5'd0 || exp_q.size() == 0) begin
            fails++; $display("FAIL full_commit got reg=%0d want 1", set_reg_id);
        end else begin
            e = exp_q.pop_front();
            if (set_reg_id !== e.rd || set_val !== e.val || set_reg_on_rob_id !== e.id) begin
                fails++; $display("FAIL full_commit got %0d/%h/%0d want %0d/%h/%0d",
                                  set_reg_id, set_val, set_reg_on_rob_id, e.rd, e.val, e.id);
            end
        end
        @(negedge clk_in);
        drive_idle();
        drive_issue(2'd0, 5'd9, 1'b0, 1'b0, 32'd0);
        #1;
        tests++;
        if (full !== 1'b0 || issue_rob_id !== 3'd0 || set_dep_reg_id !== 5'd9) begin
            fails++; $display("FAIL full_tail_wrap got full=%b id=%0d dep=%0d want 0/0/9",
                              full, issue_rob_id, set_dep_reg_id);
        end
        @(negedge clk_in);
        drive_idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        @(negedge clk_in);
        drive_issue(2'd1, 5'd0, 1'b0, 1'b0, 32'h4);
        @(negedge clk_in);
        drive_issue(2'd0, 5'd7, 1'b0, 1'b1, 32'h77);
        @(negedge clk_in);
        drive_idle();
        drive_cdb(3'd0, 32'h100, 1'b1);
        @(negedge clk_in);
        drive_idle();
        #1;
        tests++;
        if (rob_clear !== 1'b0 || set_reg_id !== 5'd0) begin
            fails++; $display("FAIL br_commit_cycle got clr=%b reg=%0d want 0/0", rob_clear, set_reg_id);
        end
        @(negedge clk_in);
        drive_issue(2'd0, 5'd3, 1'b0, 1'b1, 32'h5);
        #1;
        tests++;
        if (rob_clear !== 1'b1 || clear_pc !== 32'h100 || set_reg_id !== 5'd0 || set_dep_reg_id !== 5'd0) begin
            fails++; $display("FAIL br_flush got clr=%b pc=%h reg=%0d dep=%0d want 1/100/0/0",
                              rob_clear, clear_pc, set_reg_id, set_dep_reg_id);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            drive_idle();
            #1;
            tests++;
            if (rob_clear !== 1'b0 || set_reg_id !== 5'd0 || issue_rob_id !== 3'd0 || full !== 1'b0) begin
                fails++; $display("FAIL br_after_flush_%0d got clr=%b reg=%0d tail=%0d full=%b want 0/0/0/0",
                                  i, rob_clear, set_reg_id, issue_rob_id, full);
            end
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            drive_issue(2'd0, 5'(10 + i), 1'b0, 1'b0, 32'd0);
            exp_q.push_back('{rd: 5'(10 + i), val: 32'h10 + 32'(i * 17), id: 3'(i)});
        end
        @(negedge clk_in);
        drive_idle();
        drive_cdb(3'd2, 32'h32, 1'b0);
        @(negedge clk_in);
        drive_idle();
        drive_cdb(3'd1, 32'h21, 1'b0);
        #1;
        tests++;
        if (set_reg_id !== 5'd0) begin
            fails++; $display("FAIL ooo_no_early_commit got reg=%0d want 0", set_reg_id);
        end
        @(negedge clk_in);
        drive_idle();
        drive_cdb(3'd0, 32'h10, 1'b0);
        #1;
        tests++;
        if (set_reg_id !== 5'd0) begin
            fails++; $display("FAIL ooo_head_cdb_cycle got reg=%0d want 0", set_reg_id);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            drive_idle();
            #1;
            tests++;
            if (set_reg_id === 5'd0 || exp_q.size() == 0) begin
                fails++; $display("FAIL ooo_commit_%0d got reg=%0d want a commit", i, set_reg_id);
            end else begin
                e = exp_q.pop_front();
                if (set_reg_id !== e.rd || set_val !== e.val || set_reg_on_rob_id !== e.id) begin
                    fails++; $display("FAIL ooo_commit_%0d got %0d/%h/%0d want %0d/%h/%0d", i,
                                      set_reg_id, set_val, set_reg_on_rob_id, e.rd, e.val, e.id);
                end
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        @(negedge clk_in);
        drive_issue(2'd0, 5'd3, 1'b0, 1'b1, 32'h33);
        exp_q.push_back('{rd: 5'd3, val: 32'h33, id: 3'd0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            drive_idle();
            rdy_in = 1'b0;
            drive_issue(2'd0, 5'd6, 1'b0, 1'b1, 32'h66);
            #1;
            tests++;
            if (set_reg_id !== 5'd0 || set_dep_reg_id !== 5'd0 || issue_rob_id !== 3'd1) begin
                fails++; $display("FAIL pause_%0d got reg=%0d dep=%0d tail=%0d want 0/0/1",
                                  i, set_reg_id, set_dep_reg_id, issue_rob_id);
            end
        end
        @(negedge clk_in);
        drive_idle();
        rdy_in = 1'b1;
        #1;
        tests++;
        if (set_reg_id === 5'd0 || exp_q.size() == 0) begin
            fails++; $display("FAIL pause_resume got reg=%0d want 3", set_reg_id);
        end else begin
            e = exp_q.pop_front();
            if (set_reg_id !== e.rd || set_val !== e.val || set_reg_on_rob_id !== e.id) begin
                fails++; $display("FAIL pause_resume got %0d/%h/%0d want %0d/%h/%0d",
                                  set_reg_id, set_val, set_reg_on_rob_id, e.rd, e.val, e.id);
            end
        end
    endtask

    task automatic test_store_exit();
        do_reset();
        @(negedge clk_in);
        drive_issue(2'd2, 5'd0, 1'b0, 1'b1, 32'd0);
        @(negedge clk_in);
        drive_issue(2'd3, 5'd0, 1'b0, 1'b1, 32'd0);
        #1;
        tests++;
        if (store_commit !== 1'b1 || set_reg_id !== 5'd0) begin
            fails++; $display("FAIL store_commit got st=%b reg=%0d want 1/0", store_commit, set_reg_id);
        end
        @(negedge clk_in);
        drive_idle();
        #1;
        tests++;
        if (store_commit !== 1'b0 || exit_commit !== 1'b0) begin
            fails++; $display("FAIL exit_commit_cycle got st=%b exit=%b want 0/0", store_commit, exit_commit);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            #1;
            tests++;
            if (exit_commit !== 1'b1) begin
                fails++; $display("FAIL exit_sticky_%0d got=%b want=1", i, exit_commit);
            end
        end
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        drive_idle();
        test_reset();
        test_basic();
        test_full();
        test_mispredict();
        test_out_of_order();
        test_pause();
        test_store_exit();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
